// File: rtl/i2s_pkg.sv
// i2s_pkg: shared widths, stereo sample type and a counter-width helper for the I2S transmitter.
package i2s_pkg;
   localparam int SAMPLE_W     = 24;
   localparam int SLOT_W       = 32;
   localparam int BCLK_DIV_DEF = 4;
   localparam int FRAME_BITS   = 2*SLOT_W;
   typedef struct packed {
      logic signed [SAMPLE_W-1:0] left;
      logic signed [SAMPLE_W-1:0] right;
   } stereo_sample_t;
   function automatic int cw(input int x);
      return (x > 1) ? $clog2(x) : 1;
   endfunction
endpackage

// File: rtl/i2s_clkgen.sv
// i2s_clkgen: BCLK divider and frame bit counter; fall_evt marks each BCLK 1->0 transition.
module i2s_clkgen
   import i2s_pkg::*;
#(
   parameter int SLOT     = SLOT_W,
   parameter int BCLK_DIV = BCLK_DIV_DEF
) (
   input  logic                     clk,
   input  logic                     reset_n,
   output logic                     bclk,
   output logic                     fall_evt,
   output logic                     frame_evt,
   output logic [cw(2*SLOT)-1:0]    bit_cnt
);
   localparam int DW = cw(BCLK_DIV);
   localparam int BW = cw(2*SLOT);
   logic [DW-1:0] div_cnt;
   logic          wrap;
   assign wrap      = div_cnt == DW'(BCLK_DIV-1);
   assign fall_evt  = wrap && bclk;
   assign frame_evt = fall_evt && (bit_cnt == BW'(2*SLOT-1));
   // bit_cnt resets to the last bit so the first fall event starts a frame
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         div_cnt <= '0;
         bclk    <= 1'b0;
         bit_cnt <= BW'(2*SLOT-1);
      end else begin
         div_cnt <= wrap ? '0 : div_cnt + 1'b1;
         if (wrap) bclk <= ~bclk;
         if (fall_evt) bit_cnt <= frame_evt ? '0 : bit_cnt + 1'b1;
      end
   end
endmodule

// File: rtl/i2s_tx.sv
// i2s_tx: stereo Philips I2S transmitter with a one-pair holding register.
// Define I2S_TX_UNDERRUN_ZERO_EN to output silence on underrun instead of repeating the last pair.
module i2s_tx
   import i2s_pkg::*;
#(
   parameter int N        = SAMPLE_W,
   parameter int SLOT     = SLOT_W,
   parameter int BCLK_DIV = BCLK_DIV_DEF
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic signed [N-1:0] left_in,
   input  logic signed [N-1:0] right_in,
   input  logic                valid_in,
   output logic                ready_out,
   output logic                i2s_bclk,
   output logic                i2s_lrclk,
   output logic                i2s_sdata,
   output logic                underrun
);
   localparam int BW = cw(2*SLOT);
`ifdef I2S_TX_UNDERRUN_ZERO_EN
   localparam bit ZERO_EN = 1'b1;
`else
   localparam bit ZERO_EN = 1'b0;
`endif
   if (N > SLOT-1) begin : g_bad_width
      $error("i2s_tx: N must not exceed SLOT-1");
   end
   logic          fall_evt, frame_evt, accept, hold_full, lr_nxt, sd_nxt;
   logic [BW-1:0] bit_cnt, nb, p;
   logic [2*N-1:0] hold, frame;
   logic [N-1:0]  ch, sh;
   i2s_clkgen #(.SLOT(SLOT), .BCLK_DIV(BCLK_DIV)) u_clkgen (
      .clk       (clk),
      .reset_n   (reset_n),
      .bclk      (i2s_bclk),
      .fall_evt  (fall_evt),
      .frame_evt (frame_evt),
      .bit_cnt   (bit_cnt)
   );
   assign hold_full = !ready_out;
   assign accept    = valid_in && ready_out;
   // serialiser looks ahead to the bit position taking effect at this fall event
   always_comb begin
      nb     = frame_evt ? '0 : bit_cnt + 1'b1;
      lr_nxt = nb >= BW'(SLOT);
      p      = lr_nxt ? nb - BW'(SLOT) : nb;
      ch     = lr_nxt ? frame[N-1:0] : frame[2*N-1:N];
      sh     = ch << (p - 1'b1);
      sd_nxt = (p != '0) && (p <= BW'(N)) && sh[N-1];
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ready_out <= 1'b1;
         underrun  <= 1'b0;
         hold      <= '0;
         frame     <= '0;
         i2s_lrclk <= 1'b0;
         i2s_sdata <= 1'b0;
      end else begin
         underrun  <= frame_evt && !hold_full;
         ready_out <= accept ? 1'b0 : (frame_evt || ready_out);
         if (accept) hold <= {left_in, right_in};
         if (frame_evt) frame <= hold_full ? hold : (ZERO_EN ? '0 : frame);
         if (fall_evt) begin
            i2s_lrclk <= lr_nxt;
            i2s_sdata <= sd_nxt;
         end
      end
   end
endmodule

// File: tb/tb_i2s_tx.sv
// tb_i2s_tx: randomized bench for i2s_tx against a time-based frame model.
module tb_i2s_tx;
   import i2s_pkg::*;
   localparam int BD = BCLK_DIV_DEF;
   localparam int FR = 2*FRAME_BITS*BD;
   logic clk = 1'b0, reset_n = 1'b0, valid_in = 1'b0;
   logic signed [SAMPLE_W-1:0] left_in = '0, right_in = '0;
   logic ready_out, i2s_bclk, i2s_lrclk, i2s_sdata, underrun;
   int n_cmp = 0, n_bad = 0, t = 0, ncap = 0;
   bit m_full, e_lr, e_sd, fword_ok, prev_bclk;
   logic [47:0] m_hold, m_frame;
   logic [63:0] cap, fword;

   i2s_tx dut (
      .clk(clk), .reset_n(reset_n), .left_in(left_in), .right_in(right_in),
      .valid_in(valid_in), .ready_out(ready_out), .i2s_bclk(i2s_bclk),
      .i2s_lrclk(i2s_lrclk), .i2s_sdata(i2s_sdata), .underrun(underrun)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, t);
      end
   endtask

   // expected 64-bit BCLK capture for one frame: one-bit delay, 24 data bits, zero padding
   function automatic logic [63:0] word(input logic [47:0] pr);
      return {1'b0, pr[47:24], 7'b0, 1'b0, pr[23:0], 7'b0};
   endfunction

   function automatic stereo_sample_t rnd();
      stereo_sample_t s;
      s.left  = 24'($urandom);
      s.right = 24'($urandom);
      return s;
   endfunction

   task automatic step(input bit v, input stereo_sample_t s, output bit acc);
      bit fe, fall, und;
      int b, p;
      logic [23:0] ch;
      @(negedge clk);
      valid_in = v; left_in = s.left; right_in = s.right;
      t++;
      fe   = (t % FR) == 2*BD;
      fall = (t % (2*BD)) == 0;
      acc  = v && !m_full;
      und  = fe && !m_full;
      if (fe) begin
         if (fword_ok) begin
            check("bit_count", 64'(ncap), 64'd64);
            check("frame_bits", cap, fword);
         end
         if (m_full) begin
            m_frame = m_hold;
            m_full  = 1'b0;
         end
`ifdef I2S_TX_UNDERRUN_ZERO_EN
         else m_frame = '0;
`endif
         fword = word(m_frame); fword_ok = 1'b1; ncap = 0;
      end
      if (acc) begin
         m_hold = {s.left, s.right};
         m_full = 1'b1;
      end
      if (fall) begin
         b    = (t/(2*BD) - 1) % FRAME_BITS;
         e_lr = b >= SLOT_W;
         p    = b % SLOT_W;
         ch   = e_lr ? m_frame[23:0] : m_frame[47:24];
         e_sd = (p >= 1 && p <= SAMPLE_W) ? ch[SAMPLE_W-p] : 1'b0;
      end
      @(posedge clk); #1;
      check("bclk", 64'(i2s_bclk), 64'((t/BD) % 2));
      check("lrclk", 64'(i2s_lrclk), 64'(e_lr));
      check("sdata", 64'(i2s_sdata), 64'(e_sd));
      check("ready", 64'(ready_out), 64'(!m_full));
      check("underrun", 64'(underrun), 64'(und));
      if (i2s_bclk && !prev_bclk) begin
         cap = {cap[62:0], i2s_sdata};
         ncap++;
      end
      prev_bclk = i2s_bclk;
   endtask

   task automatic do_reset();
      @(negedge clk); #2 reset_n = 1'b0; #1;
      check("rst_bclk", 64'(i2s_bclk), 64'd0);
      check("rst_lrclk", 64'(i2s_lrclk), 64'd0);
      check("rst_sdata", 64'(i2s_sdata), 64'd0);
      check("rst_underrun", 64'(underrun), 64'd0);
      check("rst_ready", 64'(ready_out), 64'd1);
      t = 0; m_full = 0; m_hold = '0; m_frame = '0; e_lr = 0; e_sd = 0;
      fword_ok = 0; ncap = 0; prev_bclk = 0; cap = '0; valid_in = 1'b0;
      repeat (3) @(posedge clk);
      #2 reset_n = 1'b1;
   endtask

   task automatic idle(input int n);
      bit acc;
      for (int i = 0; i < n; i++) step(1'b0, rnd(), acc);
   endtask

   task automatic send(input stereo_sample_t s);
      bit acc = 1'b0;
      int k = 0;
      while (!acc && k < 2*FR) begin
         step(1'b1, s, acc);
         k++;
      end
      check("send_accepted", 64'(acc), 64'd1);
   endtask

   task automatic stream(input int n, input bit always_valid);
      bit acc, pend = 1'b0;
      stereo_sample_t cur = rnd();
      for (int i = 0; i < n; i++) begin
         if (!pend) begin
            pend = always_valid || ($urandom_range(0, 3) == 0);
            if (pend) cur = rnd();
         end
         step(pend, cur, acc);
         if (acc) pend = 1'b0;
      end
   endtask

   initial begin
      stereo_sample_t s;
      bit acc;
      do_reset();
      idle(3*FR);
      s.left = 24'h800001; s.right = 24'h7FFFFE;
      send(s);
      idle(2*FR + 20);
      stream(4*FR, 1'b1);
      s.left = 24'h123456; s.right = 24'hABCDEF;
      send(s);
      idle(3*FR);
      while ((t + 1) % FR != 2*BD) step(1'b0, rnd(), acc);
      step(1'b1, rnd(), acc);
      check("edge_accept", 64'(acc), 64'd1);
      idle(2*FR + 20);
      stream(6*FR, 1'b0);
      send(rnd());
      while (t % FR != 2*BD + 40*2*BD) step(1'b0, rnd(), acc);
      idle(3);
      do_reset();
      idle(2*FR + 20);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/i2s_tx.md
Name: i2s_tx

Overview:
Stereo I2S transmitter at the output end of the audio filter chain. It accepts 24-bit signed left/right sample pairs from the FIR stage through a valid/ready handshake and serialises them to an external DAC. It generates BCLK, LRCLK and SDATA from the system clock in standard Philips I2S format: MSB first, data delayed one BCLK after each LRCLK edge.

Parameters:
N, 24, sample width in bits, two's complement; N <= SLOT-1 is required.
SLOT, 32, BCLK periods per channel slot; a frame is 2*SLOT BCLK periods.
BCLK_DIV, 4, clk cycles per BCLK half-period; must be >= 1.

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
left_in  input  N  left sample, signed
right_in  input  N  right sample, signed
valid_in  input  1  sample pair present on left_in/right_in
ready_out  output  1  holding register empty; pair accepted when valid_in && ready_out
i2s_bclk  output  1  bit clock; DAC samples SDATA on its rising edge
i2s_lrclk  output  1  word select; 0 = left slot, 1 = right slot
i2s_sdata  output  1  serial data; changes only on BCLK falling events
underrun  output  1  one-cycle pulse when a frame starts with no new sample pair

Behaviour:
- Clocking and reset: one clock (clk). Reset is asynchronous, active-low (reset_n). All state is registered; outputs come straight from registers.
- Reset values: i2s_bclk=0, i2s_lrclk=0, i2s_sdata=0, ready_out=1, underrun=0. Internal reset values: div_cnt=0, bit_cnt=2*SLOT-1, holding and frame registers=0.
- Divider:
  - div_cnt counts 0..BCLK_DIV-1. At BCLK_DIV-1 it wraps to 0 and i2s_bclk toggles.
  - A toggle 1->0 is a "fall event".
- Bit counter:
  - bit_cnt advances on each fall event, 0..2*SLOT-1, then wraps to 0.
  - The wrap to 0 is the "frame event". The first fall event after reset is therefore a frame event.
- Outputs updated on each fall event, using the new bit_cnt value:
  - i2s_lrclk = (bit_cnt >= SLOT).
  - Let p = bit_cnt mod SLOT. For p in 1..N, i2s_sdata = bit (N-p) of that slot's channel sample. For p=0 or p>N, i2s_sdata = 0.
- Frame event:
  - If the holding register is full: frame register <= holding register; holding becomes empty.
  - If it is empty: frame register is kept (see Optional Feature) and underrun pulses high for exactly one clk.
- Handshake:
  - ready_out = !hold_full, registered.
  - Accept on valid_in && ready_out: holding <= {left_in, right_in}; hold_full=1.
  - valid_in while ready_out=0 is ignored; the source must hold its data.
- Simultaneous accept and frame event in the same cycle: the frame event sees the old, empty holding register, so underrun pulses. The accept still completes and hold_full ends at 1.
- Latency: an accepted pair is output starting at the next frame event. Its left MSB appears on SDATA one BCLK period after that event (p=1).
- Period: frame = 2*SLOT*2*BCLK_DIV clk cycles (default 512).
- Reset asserted mid-frame: all outputs return to reset values immediately and any pending pair is discarded. After release, the sequence restarts at the first frame event.
- No backpressure to the DAC. Throughput is fixed at one pair per frame.

Optional Feature:
- Macro I2S_TX_UNDERRUN_ZERO_EN.
- Defined: on underrun the frame register is loaded with zeros, giving silence.
- Undefined: on underrun the frame register keeps the previous pair, so the last sample is repeated.
- The underrun pulse behaves identically in both cases.

Decomposition:
- Package i2s_pkg holds:
  - constants SAMPLE_W=24, SLOT_W=32, default BCLK_DIV;
  - typedef stereo_sample_t, a packed struct of signed left and right fields of SAMPLE_W bits;
  - localparam FRAME_BITS = 2*SLOT_W.
- Sub-module i2s_clkgen: BCLK divider plus bit counter; emits bclk, fall_evt, frame_evt and bit_cnt.
- The top level holds the holding register, frame register, handshake and serialiser mux.

Test Plan:
1. Reset, then idle with no valid_in -> first frame event at clk 8 (bclk 1->0 at 2*BCLK_DIV). underrun pulses once per 512 clks; SDATA stays 0 in both builds.
2. Send one pair L=24'h800001, R=24'h7FFFFE -> bench captures on BCLK rising edges.
   - LRCLK low slot: bits 1..24 = 100000000000000000000001.
   - LRCLK high slot: bits 1..24 = 011111111111111111111110.
   - All other slot bits are 0.
3. Keep valid_in held high continuously -> exactly one acceptance per frame, ready_out low ~511 of 512 clks, underrun never asserted, pairs serialised in order.
4. Stop the source after pair 24'h123456/24'hABCDEF.
   - Undefined build: the next frame repeats 123456/ABCDEF with an underrun pulse.
   - Defined build: the next frame is all zeros with an underrun pulse.
5. Assert valid_in in the exact cycle of a frame event while empty -> underrun=1 that cycle, hold_full=1 next cycle, and the pair is output in the following frame.
6. Assert reset_n low mid right slot (bit_cnt=40) -> bclk, lrclk, sdata and underrun go to 0 and ready_out to 1 immediately. After release, timing matches scenario 1.
